// File: rtl/osc_half_period_meter.sv
// Oscillator half-period meter: times the interval from a qualified peak
// (a falling step above Q3) to a qualified trough (a rising step below Q1).
module osc_half_period_meter #(
  parameter int               DEPTH   = 16,
  parameter logic [DEPTH-1:0] Q1      = DEPTH'(2**(DEPTH-2)),
  parameter logic [DEPTH-1:0] Q3      = DEPTH'(3*2**(DEPTH-2)),
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'hFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] v,
  input  logic             restart,
  output logic [CNT_W-1:0] half_period,
  output logic             hp_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    PRIME,
    SEEK_PEAK,
    SEEK_TROUGH
  } state_e;

  state_e           state_q;
  logic [DEPTH-1:0] v_d1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hp_q;
  logic             hp_valid_q;
  logic             timeout_q;
  logic             busy_q;
  logic             peak_hit;
  logic             trough_hit;

  assign peak_hit   = (v < v_d1_q) && (v > Q3);
  assign trough_hit = (v > v_d1_q) && (v < Q1);
  assign cnt_d      = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRIME;
      v_d1_q     <= '0;
      cnt_q      <= '0;
      hp_q       <= '0;
      hp_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      v_d1_q     <= v;
      hp_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (restart) begin
        state_q <= PRIME;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          PRIME: state_q <= SEEK_PEAK;
          SEEK_PEAK: begin
            if (peak_hit) begin
              state_q <= SEEK_TROUGH;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          SEEK_TROUGH: begin
            cnt_q <= cnt_d;
            // a trough on the timeout cycle still counts as a measurement
            if (trough_hit) begin
              hp_q       <= cnt_q + 1'b1;
              hp_valid_q <= 1'b1;
              state_q    <= SEEK_PEAK;
              busy_q     <= 1'b0;
            end else if (cnt_q == TIMEOUT) begin
              timeout_q <= 1'b1;
              state_q   <= SEEK_PEAK;
              busy_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= PRIME;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign half_period = hp_q;
  assign hp_valid    = hp_valid_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_osc_half_period_meter.sv
// Scoreboard bench for osc_half_period_meter: a cycle-stamped reference
// model queues expected pulses, a negedge monitor pops and compares them.
module tb_osc_half_period_meter;

  localparam int DEPTH = 16;
  localparam int CNT_W = 24;
  localparam logic [15:0] Q1 = 16'h4000;
  localparam logic [15:0] Q3 = 16'hC000;
  localparam int TMO = 1000;

  logic             clk;
  logic             rst_n;
  logic [DEPTH-1:0] v;
  logic             restart;
  logic [CNT_W-1:0] half_period;
  logic             hp_valid;
  logic             timeout;
  logic             busy;

  osc_half_period_meter #(
    .DEPTH(DEPTH), .Q1(Q1), .Q3(Q3),
    .CNT_W(CNT_W), .TIMEOUT(24'(TMO))
  ) dut (
    .clk(clk), .rst_n(rst_n), .v(v), .restart(restart),
    .half_period(half_period), .hp_valid(hp_valid),
    .timeout(timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int val;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  vecs = 0;
  int  errs = 0;
  int  cyc = 0;
  int  m_phase = 0;
  int  m_prev = 0;
  int  m_peak = 0;
  int  m_hp = 0;
  bit  m_busy = 0;
  int  pulses = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: events are stamped with absolute cycle numbers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_prev = 0; m_hp = 0; m_busy = 0;
      q.delete();
    end else begin
      int vi;
      int d;
      bit pk;
      bit tr;
      cyc++;
      vi = int'(v);
      pk = (vi < m_prev) && (vi > int'(Q3));
      tr = (vi > m_prev) && (vi < int'(Q1));
      if (restart) m_phase = 0;
      else if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (pk) begin m_phase = 2; m_peak = cyc; end
      end else begin
        d = cyc - m_peak;
        if (tr) begin
          q.push_back('{0, d, cyc}); m_hp = d; m_phase = 1;
        end else if (d == TMO + 1) begin
          q.push_back('{1, m_hp, cyc}); m_phase = 1;
        end
      end
      m_prev = vi;
      m_busy = (m_phase == 2);
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      chk("busy", busy, m_busy);
      chk("half_period_held", half_period, m_hp);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_pulse_cycle", cyc, e.cyc);
      end
      if (hp_valid || timeout) begin
        pulses++;
        chk("pulse_exclusive", hp_valid & timeout, 0);
        if (q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_is_timeout", timeout, e.is_to);
          chk("pulse_half_period", half_period, e.val);
        end
      end
    end
  end

  task automatic drive(input int val, input bit rs = 0);
    @(negedge clk);
    v = DEPTH'(val);
    restart = rs;
  endtask

  task automatic ramp(input int from, input int to, input int steps);
    for (int i = 1; i <= steps; i++)
      drive(from + ((to - from) * i) / steps, ($urandom_range(0, 999) == 0));
  endtask

  initial begin
    int base;
    int lo;
    int hi;
    rst_n = 1'b0; v = '0; restart = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_half_period", half_period, 0);
    chk("rst_hp_valid", hp_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Full-scale triangle, period 200: expect 100 each half
    for (int t = 0; t < 1000; t++) begin
      int p;
      p = t % 200;
      drive(p < 100 ? p * 655 : (200 - p) * 655);
    end
    base = pulses;

    // Peak then hold above Q3: timeout only
    ramp(16'h3000, 16'hF000, 20);
    drive(16'hE000);
    repeat (1100) drive(16'hC100);

    // Restart on the trough-qualifying sample
    ramp(16'hC100, 16'hF000, 10);
    ramp(16'hF000, 16'h1000, 30);
    drive(16'h1100, 1'b1);
    ramp(16'h1100, 16'hF000, 25);
    ramp(16'hF000, 16'h1000, 25);
    ramp(16'h1000, 16'h2000, 5);

    // Async reset mid SEEK_TROUGH
    ramp(16'h2000, 16'hF000, 20);
    ramp(16'hF000, 16'h9000, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hp_valid", hp_valid, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_half_period", half_period, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ramp(16'h9000, 16'h1000, 15);
    ramp(16'h1000, 16'hF000, 30);
    ramp(16'hF000, 16'h0800, 44);
    ramp(16'h0800, 16'h3000, 5);

    // Small sine inside the thresholds: no pulses at all
    base = pulses;
    for (int t = 0; t < 10000; t++)
      drive(32768 + int'(8000.0 * $sin(2.0 * 3.14159265 * t / 300.0)));
    chk("inband_no_pulses", pulses - base, 0);

    // Random triangles, some slow enough to time out
    for (int s = 0; s < 20; s++) begin
      lo = $urandom_range(0, 16'h5000);
      hi = $urandom_range(16'hB000, 16'hFFFF);
      ramp(int'(v), hi, $urandom_range(3, 1200));
      ramp(hi, lo, $urandom_range(3, 1200));
    end

    repeat (5) drive(int'(v));
    chk("queue_drained", q.size(), 0);
    chk("pulses_seen_nonzero", pulses > 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
